// File: rtl/trng_sync_mc.sv
// Multi-channel ROSC synchroniser: selects one channel, decimates it, delivers bits over valid/ready.
// Latency: rnd_src edge to sync_data = SYNC_STAGES+1 cycles once warm; first sample WARMUP_CYCLES+sample_div+1 after enable.
// Backpressure: a strobe while a sample is pending and not accepted drops the new bit and sets sticky overrun.
// Optional ROSC frequency BIST is compiled in when RNG_BIST_EN is defined.
module trng_sync_mc #(
  parameter int NUM_SRC       = 4,
  parameter int SEL_W         = 2,
  parameter int SYNC_STAGES   = 3,
  parameter int WARMUP_CYCLES = 3,
  parameter int DIV_W         = 8,
  parameter int ROSC_CNT_W    = 22,
  parameter int BIST_WIN_W    = 17
) (
  input  logic                          rng_clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            rnd_src,
  input  logic                          rnd_src_en,
  input  logic [SEL_W-1:0]              src_sel,
  input  logic [DIV_W-1:0]              sample_div,
  input  logic                          scan_mode,
  input  logic                          sync_ready,
  output logic                          sync_valid,
  output logic                          sync_data,
  output logic                          overrun,
  input  logic                          bist_start,
  output logic                          bist_busy,
  output logic                          bist_done,
  output logic [NUM_SRC*ROSC_CNT_W-1:0] rosc_cnt
);

  localparam int WC_W = $clog2(WARMUP_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sy_q [NUM_SRC];
  logic [SEL_W-1:0]       sel_prev_q;
  logic [WC_W-1:0]        warm_cnt_q, warm_cnt_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic                   valid_q, valid_d;
  logic                   data_q, data_d;
  logic                   ovr_q, ovr_d;
  logic                   sel_bit, warm, strobe;

  // Synchroniser chains: every channel always clocked, scan forces the entry flop to 0
  always_ff @(posedge rng_clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst) sy_q[i] <= '0;
      else     sy_q[i] <= {sy_q[i][SYNC_STAGES-2:0], (scan_mode ? 1'b0 : rnd_src[i])};
    end
  end

  // Channel mux: an out-of-range select reads as 0
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_sel == SEL_W'(i)) sel_bit = sy_q[i][SYNC_STAGES-1];
    end
  end

  assign warm   = (warm_cnt_q == WC_W'(WARMUP_CYCLES));
  assign strobe = rnd_src_en && warm && (div_cnt_q >= sample_div);

  // Warm-up and divider next state; >= lets a reduced divider fire immediately
  always_comb begin
    warm_cnt_d = warm_cnt_q;
    div_cnt_d  = div_cnt_q;
    if (!rnd_src_en || (src_sel != sel_prev_q)) warm_cnt_d = '0;
    else if (!warm)                             warm_cnt_d = warm_cnt_q + WC_W'(1);
    if (!rnd_src_en || !warm) div_cnt_d = '0;
    else if (strobe)          div_cnt_d = '0;
    else                      div_cnt_d = div_cnt_q + DIV_W'(1);
  end

  // Output register next state: load on strobe when free, drop and flag when still pending
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (!rnd_src_en) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else if (strobe) begin
      if (!valid_q || sync_ready) begin
        data_d  = sel_bit;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (sync_ready) begin
      valid_d = 1'b0;
    end
  end

  // Control and output state registers
  always_ff @(posedge rng_clk) begin
    if (rst) begin
      sel_prev_q <= '0;
      warm_cnt_q <= '0;
      div_cnt_q  <= '0;
      valid_q    <= 1'b0;
      data_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sel_prev_q <= src_sel;
      warm_cnt_q <= warm_cnt_d;
      div_cnt_q  <= div_cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      ovr_q      <= ovr_d;
    end
  end

  assign sync_valid = valid_q;
  assign sync_data  = data_q;
  assign overrun    = ovr_q;

`ifdef RNG_BIST_EN
  logic [NUM_SRC-1:0]            edge_prev_q;
  logic [ROSC_CNT_W-1:0]         edge_cnt_q [NUM_SRC];
  logic [BIST_WIN_W-1:0]         win_cnt_q;
  logic                          busy_q, done_q;
  logic [NUM_SRC*ROSC_CNT_W-1:0] rosc_q;

  // Frequency BIST: count rising edges per channel over a fixed window, publish at window end
  always_ff @(posedge rng_clk) begin
    if (rst) begin
      edge_prev_q <= '0;
      win_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rosc_q      <= '0;
      for (int i = 0; i < NUM_SRC; i++) edge_cnt_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) edge_prev_q[i] <= sy_q[i][SYNC_STAGES-1];
      if (bist_start && !busy_q) begin
        busy_q    <= 1'b1;
        win_cnt_q <= '0;
        for (int i = 0; i < NUM_SRC; i++) edge_cnt_q[i] <= '0;
      end else if (busy_q) begin
        win_cnt_q <= win_cnt_q + BIST_WIN_W'(1);
        for (int i = 0; i < NUM_SRC; i++) begin
          if (sy_q[i][SYNC_STAGES-1] && !edge_prev_q[i] && (edge_cnt_q[i] != '1))
            edge_cnt_q[i] <= edge_cnt_q[i] + ROSC_CNT_W'(1);
        end
        if (win_cnt_q == '1) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          for (int i = 0; i < NUM_SRC; i++) rosc_q[i*ROSC_CNT_W +: ROSC_CNT_W] <= edge_cnt_q[i];
        end
      end
    end
  end

  assign bist_busy = busy_q;
  assign bist_done = done_q;
  assign rosc_cnt  = rosc_q;
`else
  logic unused_bist;
  assign unused_bist = bist_start | (BIST_WIN_W == 0);
  assign bist_busy   = 1'b0;
  assign bist_done   = 1'b0;
  assign rosc_cnt    = '0;
`endif

endmodule

// File: tb/tb_trng_sync_mc.sv
// Scoreboard bench for trng_sync_mc: stimulus queues expected (cycle, bit) samples,
// a monitor pops one on every accepted handshake and compares cycle and data.
module tb_trng_sync_mc;
  localparam int NS = 3;
  localparam int CW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] rnd_src;
  logic          rnd_src_en;
  logic [1:0]    src_sel;
  logic [7:0]    sample_div;
  logic          scan_mode;
  logic          sync_ready;
  logic          sync_valid, sync_data, overrun;
  logic          bist_start, bist_busy, bist_done;
  logic [NS*CW-1:0] rosc_cnt;

  trng_sync_mc #(
    .NUM_SRC(NS), .SEL_W(2), .SYNC_STAGES(3), .WARMUP_CYCLES(3),
    .DIV_W(8), .ROSC_CNT_W(CW), .BIST_WIN_W(6)
  ) dut (
    .rng_clk(clk), .rst(rst), .rnd_src(rnd_src), .rnd_src_en(rnd_src_en),
    .src_sel(src_sel), .sample_div(sample_div), .scan_mode(scan_mode),
    .sync_ready(sync_ready), .sync_valid(sync_valid), .sync_data(sync_data),
    .overrun(overrun), .bist_start(bist_start), .bist_busy(bist_busy),
    .bist_done(bist_done), .rosc_cnt(rosc_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic d; } smp_t;
  smp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_s(input int n, input logic d);
    smp_t s;
    s.cyc = n;
    s.d   = d;
    sb.push_back(s);
  endtask

  // Monitor: every handshake must match the oldest queued sample
  always @(negedge clk) begin
    if (!rst && sync_valid && sync_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_sample", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        smp_t s;
        s = sb.pop_front();
        chk("sample_cycle", 64'(cyc), 64'(s.cyc));
        chk("sample_data", 64'(sync_data), 64'(s.d));
      end
    end
  end

  int c, s0, done_n, done_at;
  logic busy_seen;

  initial begin
    rst = 1'b1; rnd_src = 3'b001; rnd_src_en = 1'b0; src_sel = 2'd0;
    sample_div = 8'd0; scan_mode = 1'b0; sync_ready = 1'b1; bist_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(sync_valid), 0);
    chk("rst_data", 64'(sync_data), 0);
    chk("rst_overrun", 64'(overrun), 0);
    chk("rst_bist", 64'({bist_busy, bist_done}), 0);
    chk("rst_rosc_zero", 64'(rosc_cnt == '0), 1);
    rst = 1'b0;
    go(8);

    // Warm-up: first sample 4 cycles after enable, then one per cycle
    c = cyc;
    rnd_src_en = 1'b1;
    for (int k = 0; k < 4; k++) exp_s(c + 4 + k, 1'b1);
    // Decimation by 4, then 3->1 while div_cnt=2 fires next cycle
    go(c + 7);  sample_div = 8'd3;
    exp_s(c + 11, 1'b1); exp_s(c + 15, 1'b1); exp_s(c + 19, 1'b1);
    go(c + 21); sample_div = 8'd1;
    exp_s(c + 22, 1'b1); exp_s(c + 24, 1'b1);

    // Backpressure: held sample survives two dropped strobes
    go(c + 25); sync_ready = 1'b0; rnd_src = 3'b000;
    go(c + 28);
    chk("bp_valid", 64'(sync_valid), 1);
    chk("bp_overrun", 64'(overrun), 1);
    go(c + 30);
    chk("bp_held_data", 64'(sync_data), 1);
    chk("bp_overrun_sticky", 64'(overrun), 1);
    rnd_src_en = 1'b0;
    go(c + 31);
    chk("dis_valid", 64'(sync_valid), 0);
    chk("dis_overrun", 64'(overrun), 0);
    chk("dis_data_hold", 64'(sync_data), 1);

    // Channel switch, out-of-range select, scan
    rnd_src_en = 1'b1; sync_ready = 1'b1; sample_div = 8'd0; rnd_src = 3'b100;
    exp_s(c + 35, 1'b0); exp_s(c + 36, 1'b0); exp_s(c + 37, 1'b0);
    go(c + 37); src_sel = 2'd2;
    exp_s(c + 38, 1'b1); exp_s(c + 42, 1'b1); exp_s(c + 43, 1'b1);
    go(c + 43); src_sel = 2'd3;
    exp_s(c + 44, 1'b0); exp_s(c + 48, 1'b0); exp_s(c + 49, 1'b0);
    go(c + 49); src_sel = 2'd2;
    exp_s(c + 50, 1'b1); exp_s(c + 54, 1'b1);
    go(c + 54); scan_mode = 1'b1;
    exp_s(c + 55, 1'b1); exp_s(c + 56, 1'b1); exp_s(c + 57, 1'b1);
    exp_s(c + 58, 1'b0); exp_s(c + 59, 1'b0); exp_s(c + 60, 1'b0);
    for (int k = 55; k < 60; k++) begin
      go(c + k);
      rnd_src = ~rnd_src;
    end
    go(c + 60); rnd_src_en = 1'b0; scan_mode = 1'b0; rnd_src = 3'b000;
    go(c + 63);
    chk("scoreboard_drained", 64'(sb.size()), 0);

    // Measurement window with ch0 toggling every 4 cycles
    s0 = cyc; done_n = 0; done_at = 0; busy_seen = 1'b0;
    for (int k = 0; k < 70; k++) begin
      rnd_src    = {2'b00, 1'((k / 4) % 2)};
      bist_start = (k == 0);
      @(posedge clk); #1;
      busy_seen = busy_seen | bist_busy;
      if (bist_done) begin
        done_n++;
        done_at = cyc - s0;
      end
    end
    bist_start = 1'b0;
`ifdef RNG_BIST_EN
    chk("bist_done_count", 64'(done_n), 1);
    chk("bist_done_cycle", 64'(done_at), 65);
    chk("bist_ch0_in_range", 64'((rosc_cnt[0 +: CW] >= 7) && (rosc_cnt[0 +: CW] <= 9)), 1);
    chk("bist_ch1", 64'(rosc_cnt[CW +: CW]), 0);
    chk("bist_ch2", 64'(rosc_cnt[2*CW +: CW]), 0);
    chk("bist_busy_seen", 64'(busy_seen), 1);
`else
    chk("nobist_done", 64'(done_n), 0);
    chk("nobist_busy", 64'(busy_seen), 0);
    chk("nobist_rosc_zero", 64'(rosc_cnt == '0), 1);
`endif

    // Reset mid-window aborts the measurement
    done_n = 0;
    for (int k = 0; k < 80; k++) begin
      rnd_src    = {2'b00, 1'((k / 4) % 2)};
      bist_start = (k == 0);
      rst        = (k == 30);
      @(posedge clk); #1;
      if (bist_done) done_n++;
    end
    rst = 1'b0; bist_start = 1'b0;
    chk("abort_no_done", 64'(done_n), 0);
    chk("abort_busy", 64'(bist_busy), 0);
    chk("abort_rosc_zero", 64'(rosc_cnt == '0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
